// File: rtl/biglari_noc_pkg.sv
// Shared definitions for the biglari NoC peripherals.
// Contents: Avalon register addresses, NoC word field positions, CONTROL/STATUS bit
// positions, the transmit FSM state type and a helper that builds a valid NoC word.
// No ports (package).
package biglari_noc_pkg;

   localparam int unsigned AVS_ADDR_W = 2;
   localparam int unsigned AVS_DATA_W = 32;

   localparam logic [AVS_ADDR_W-1:0] ADDR_DATA    = 2'd0;
   localparam logic [AVS_ADDR_W-1:0] ADDR_STATUS  = 2'd1;
   localparam logic [AVS_ADDR_W-1:0] ADDR_CONTROL = 2'd2;

   localparam int unsigned NOC_VALID_BIT = 31;
   localparam int unsigned NOC_PAYLOAD_W = 31;

   localparam int unsigned CTRL_ENABLE_BIT  = 0;
   localparam int unsigned CTRL_OVF_CLR_BIT = 1;
   localparam int unsigned CTRL_IRQ_EN_BIT  = 2;

   localparam int unsigned STAT_EMPTY_BIT = 0;
   localparam int unsigned STAT_FULL_BIT  = 1;
   localparam int unsigned STAT_COUNT_LSB = 2;
   localparam int unsigned STAT_OVF_BIT   = 31;

   typedef enum logic {IDLE, SEND} tx_state_t;

   function automatic logic [AVS_DATA_W-1:0] noc_word(input logic [NOC_PAYLOAD_W-1:0] payload);
      logic [AVS_DATA_W-1:0] w;
      w = '0;
      w[NOC_PAYLOAD_W-1:0] = payload;
      w[NOC_VALID_BIT] = 1'b1;
      return w;
   endfunction

endpackage

// File: rtl/biglari_write_if.sv
// Avalon-MM slave bus bundle for the biglari NoC peripherals.
// Signals: avs_address (register select), avs_write/avs_writedata (write strobe and data),
// avs_read (read strobe), avs_readdata (registered read data, one cycle after avs_read).
// Modports: master (CPU side), slave (peripheral side).
interface biglari_write_if;
   import biglari_noc_pkg::*;

   logic [AVS_ADDR_W-1:0] avs_address;
   logic                  avs_write;
   logic [AVS_DATA_W-1:0] avs_writedata;
   logic                  avs_read;
   logic [AVS_DATA_W-1:0] avs_readdata;

   modport master (
      output avs_address,
      output avs_write,
      output avs_writedata,
      output avs_read,
      input  avs_readdata
   );

   modport slave (
      input  avs_address,
      input  avs_write,
      input  avs_writedata,
      input  avs_read,
      output avs_readdata
   );

endinterface

// File: rtl/biglari_tx_fifo.sv
// Synchronous FIFO with combinational head output.
// Ports: clk, reset_n (async active-low), push/wdata, pop, rdata (head), full, empty,
// count (entries held, width $clog2(DEPTH)+1).
// A push while full is accepted only if a pop happens in the same cycle; a pop while empty
// is ignored. DEPTH must be a power of two so the pointers wrap naturally.
module biglari_tx_fifo #(
   parameter int unsigned  WIDTH = 31,
   parameter int unsigned  DEPTH = 8,
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             push_ok, pop_ok;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem[rd_ptr_q];
   assign pop_ok  = pop && !empty;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign push_ok = push && (!full || pop_ok);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
         else if (pop_ok && !push_ok) count_q <= count_q - 1'b1;
      end
   end

   // Storage needs no reset: the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/biglari_write.sv
// NoC transmit peripheral: Avalon-MM slave that queues 31-bit words from the CPU and sends
// one word per TDMA round, during the slot owned by NODE_ID, on the noc_out conduit.
// Ports: clk, reset_n (async active-low), avs (Avalon slave modport), noc_out
// ([31]=valid, [30:0]=payload), irq (only with BIGLARI_WRITE_IRQ_EN defined).
// Registers: 0 DATA (W push), 1 STATUS (R), 2 CONTROL (R/W: enable, W1C overflow, irq_en),
// 3 reserved.
// Optional feature macro: BIGLARI_WRITE_IRQ_EN adds the irq output and CONTROL[2]=irq_en.
module biglari_write
   import biglari_noc_pkg::*;
#(
   parameter int unsigned NODE_ID    = 0,
   parameter int unsigned NUM_SLOTS  = 8,
   parameter int unsigned SLOT_LEN   = 4,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   biglari_write_if.slave        avs,
   output logic [AVS_DATA_W-1:0] noc_out
`ifdef BIGLARI_WRITE_IRQ_EN
   ,
   output logic                  irq
`endif
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned SW = $clog2(NUM_SLOTS);
   localparam int unsigned LW = $clog2(SLOT_LEN);

   localparam logic [SW-1:0] OWN_SLOT  = SW'(NODE_ID);
   localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_SLOTS - 1);
   localparam logic [LW-1:0] LAST_CYC  = LW'(SLOT_LEN - 1);

   // TDMA timing
   logic [LW-1:0] cyc_q;
   logic [SW-1:0] slot_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cyc_q  <= '0;
         slot_q <= '0;
      end else if (cyc_q == LAST_CYC) begin
         cyc_q  <= '0;
         slot_q <= (slot_q == LAST_SLOT) ? '0 : slot_q + 1'b1;
      end else begin
         cyc_q <= cyc_q + 1'b1;
      end
   end

   // Bus decode and control registers
   logic wr_data, wr_ctrl;
   logic enable_q, overflow_q;
   logic unused_wd;

   assign wr_data   = avs.avs_write && (avs.avs_address == ADDR_DATA);
   assign wr_ctrl   = avs.avs_write && (avs.avs_address == ADDR_CONTROL);
   assign unused_wd = avs.avs_writedata[NOC_VALID_BIT];

   // Transmit FIFO
   logic                     fifo_pop, fifo_full, fifo_empty;
   logic [NOC_PAYLOAD_W-1:0] fifo_head;
   logic [CW-1:0]            fifo_count;

   biglari_tx_fifo #(
      .WIDTH (NOC_PAYLOAD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (wr_data),
      .wdata   (avs.avs_writedata[NOC_PAYLOAD_W-1:0]),
      .pop     (fifo_pop),
      .rdata   (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // Transmit FSM
   tx_state_t             state_q;
   logic [AVS_DATA_W-1:0] noc_q;

   // Only the first cycle of the own slot can start a word, so a late enable waits a round.
   assign fifo_pop = (state_q == IDLE) && (cyc_q == '0) && (slot_q == OWN_SLOT) &&
                     enable_q && !fifo_empty;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         noc_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (fifo_pop) begin
                  state_q <= SEND;
                  noc_q   <= noc_word(fifo_head);
               end
            end
            SEND: begin
               // Entered right after cyc_q==0, so the next cyc_q==0 ends SLOT_LEN cycles.
               if (cyc_q == '0) begin
                  state_q <= IDLE;
                  noc_q   <= '0;
               end
            end
            default: begin
               state_q <= IDLE;
               noc_q   <= '0;
            end
         endcase
      end
   end

   assign noc_out = noc_q;

   // Control/overflow registers; a dropping push beats a same-cycle clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         enable_q   <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         if (wr_ctrl) enable_q <= avs.avs_writedata[CTRL_ENABLE_BIT];
         if (wr_data && fifo_full && !fifo_pop) begin
            overflow_q <= 1'b1;
         end else if (wr_ctrl && avs.avs_writedata[CTRL_OVF_CLR_BIT]) begin
            overflow_q <= 1'b0;
         end
      end
   end

`ifdef BIGLARI_WRITE_IRQ_EN
   logic irq_en_q, irq_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         if (wr_ctrl) irq_en_q <= avs.avs_writedata[CTRL_IRQ_EN_BIT];
         // Masking with the push makes irq drop the cycle right after a DATA write.
         irq_q <= irq_en_q && fifo_empty && (state_q == IDLE) && !wr_data;
      end
   end

   assign irq = irq_q;
`endif

   // Read path
   logic [AVS_DATA_W-1:0] rdata_d, rdata_q;

   always_comb begin
      rdata_d = '0;
      case (avs.avs_address)
         ADDR_STATUS: begin
            rdata_d[STAT_EMPTY_BIT]         = fifo_empty;
            rdata_d[STAT_FULL_BIT]          = fifo_full;
            rdata_d[STAT_COUNT_LSB +: CW]   = fifo_count;
            rdata_d[STAT_OVF_BIT]           = overflow_q;
         end
         ADDR_CONTROL: begin
            rdata_d[CTRL_ENABLE_BIT] = enable_q;
`ifdef BIGLARI_WRITE_IRQ_EN
            rdata_d[CTRL_IRQ_EN_BIT] = irq_en_q;
`endif
         end
         default: rdata_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rdata_q <= '0;
      end else if (avs.avs_read) begin
         rdata_q <= rdata_d;
      end
   end

   assign avs.avs_readdata = rdata_q;

endmodule

// File: tb/tb_biglari_write.sv
// Directed bench for biglari_write with NODE_ID=2, NUM_SLOTS=8, SLOT_LEN=4, FIFO_DEPTH=8.
// A round is 32 cycles; the own slot starts at round cycle 8, so a popped word is first
// visible after the edge that takes the cycle count to 9 (mod 32).
module tb_biglari_write;
   import biglari_noc_pkg::*;

   localparam int unsigned NODE  = 2;
   localparam int unsigned SLOTS = 8;
   localparam int unsigned SLEN  = 4;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned ROUND = SLOTS * SLEN;
   localparam int unsigned PHASE = NODE * SLEN + 1;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] noc_out;
`ifdef BIGLARI_WRITE_IRQ_EN
   logic        irq;
`endif

   int unsigned tick;
   int          n_checks = 0;
   int          n_errors = 0;

   biglari_write_if avs_bus ();

   biglari_write #(
      .NODE_ID    (NODE),
      .NUM_SLOTS  (SLOTS),
      .SLOT_LEN   (SLEN),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .avs     (avs_bus),
      .noc_out (noc_out)
`ifdef BIGLARI_WRITE_IRQ_EN
      ,
      .irq     (irq)
`endif
   );

   always #5 clk = ~clk;

   // Posedges since reset release; mirrors the free-running TDMA position.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) tick <= 0;
      else          tick <= tick + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h required %h", tag, got, exp);
      end
   endtask

   task automatic avs_wr_now(input logic [1:0] a, input logic [31:0] d);
      avs_bus.avs_address   = a;
      avs_bus.avs_writedata = d;
      avs_bus.avs_write     = 1'b1;
      @(negedge clk);
      avs_bus.avs_write     = 1'b0;
   endtask

   task automatic avs_wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      avs_wr_now(a, d);
   endtask

   task automatic avs_rd(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      avs_bus.avs_address = a;
      avs_bus.avs_read    = 1'b1;
      @(negedge clk);
      avs_bus.avs_read    = 1'b0;
      d = avs_bus.avs_readdata;
   endtask

   // Waits (bounded) for a valid word, checks value, length and trailing zero.
   task automatic wait_word(input string tag, input logic [31:0] exp, output int unsigned t);
      int n;
      for (int i = 0; i < 3 * ROUND; i++) begin
         if (noc_out[31]) break;
         @(negedge clk);
      end
      t = tick;
      check(tag, noc_out, exp);
      n = 0;
      while (noc_out == exp && n < SLEN + 2) begin
         n++;
         @(negedge clk);
      end
      check({tag, "_len"}, 32'(n), 32'(SLEN));
      check({tag, "_end"}, noc_out, 32'h0);
   endtask

   task automatic count_busy(input int cycles, output int nz);
      nz = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (noc_out != 32'h0) nz++;
      end
   endtask

   initial begin
      logic [31:0]  rd;
      int unsigned  t, tprev;
      int           nz;

      avs_bus.avs_address   = '0;
      avs_bus.avs_write     = 1'b0;
      avs_bus.avs_writedata = '0;
      avs_bus.avs_read      = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_noc", noc_out, 32'h0);
      check("rst_rdata", avs_bus.avs_readdata, 32'h0);
      reset_n = 1'b1;

      // Three idle rounds with enable=0
      count_busy(3 * ROUND, nz);
      check("idle_noc", 32'(nz), 32'h0);
      avs_rd(ADDR_STATUS, rd);
      check("idle_status", rd, 32'h0000_0001);
      avs_rd(ADDR_CONTROL, rd);
      check("idle_control", rd, 32'h0);
      avs_rd(2'd3, rd);
      check("reserved_rd", rd, 32'h0);

      // Two words, one per round, in the own slot
      avs_wr(ADDR_CONTROL, 32'h1);
      avs_wr(ADDR_DATA, 32'h8000_00AA);
      avs_wr(ADDR_DATA, 32'h0000_0055);
      wait_word("word_aa", 32'h8000_00AA, t);
      check("word_aa_phase", t % ROUND, PHASE);
      tprev = t;
      wait_word("word_55", 32'h8000_0055, t);
      check("word_55_gap", t - tprev, ROUND);
      avs_rd(ADDR_STATUS, rd);
      check("sent_status", rd, 32'h0000_0001);
      avs_wr(ADDR_CONTROL, 32'h3);
      avs_rd(ADDR_CONTROL, rd);
      check("ctrl_w1c_reads0", rd, 32'h0000_0001);

      // Overflow with enable=0
      avs_wr(ADDR_CONTROL, 32'h0);
      for (int i = 0; i <= int'(DEPTH); i++) begin
         avs_wr(ADDR_DATA, (i == 3) ? 32'h8000_0103 : 32'h100 + 32'(i));
      end
      avs_rd(ADDR_STATUS, rd);
      check("ovf_status", rd, 32'h8000_0022);
      avs_wr(ADDR_CONTROL, 32'h2);
      avs_rd(ADDR_STATUS, rd);
      check("ovf_clr_status", rd, 32'h0000_0022);
      avs_rd(ADDR_CONTROL, rd);
      check("ovf_clr_control", rd, 32'h0);

      // Push on the exact pop edge while full: accepted, no overflow
      avs_wr(ADDR_CONTROL, 32'h1);
      for (int i = 0; i <= int'(ROUND); i++) begin
         if (tick % ROUND == PHASE - 1) break;
         @(negedge clk);
      end
      avs_wr_now(ADDR_DATA, 32'h108);
      wait_word("fp_w0", 32'h8000_0100, t);
      tprev = t;
      avs_rd(ADDR_STATUS, rd);
      check("fp_status", rd, 32'h0000_0022);
      for (int i = 1; i <= int'(DEPTH); i++) begin
         wait_word($sformatf("fp_w%0d", i), 32'h8000_0100 + 32'(i), t);
         check($sformatf("fp_gap%0d", i), t - tprev, ROUND);
         tprev = t;
      end
      avs_rd(ADDR_STATUS, rd);
      check("fp_drained", rd, 32'h0000_0001);

      // Asynchronous reset in the middle of a SEND
      avs_wr(ADDR_DATA, 32'h77);
      avs_wr(ADDR_DATA, 32'h78);
      for (int i = 0; i < 3 * int'(ROUND); i++) begin
         if (noc_out[31]) break;
         @(negedge clk);
      end
      check("rst_pre", noc_out, 32'h8000_0077);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1 check("rst_async_noc", noc_out, 32'h0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      avs_rd(ADDR_STATUS, rd);
      check("rst_fifo_empty", rd, 32'h0000_0001);
      avs_wr(ADDR_CONTROL, 32'h1);
      count_busy(2 * ROUND, nz);
      check("rst_no_tx", 32'(nz), 32'h0);

`ifdef BIGLARI_WRITE_IRQ_EN
      check("irq_off", 32'(irq), 32'h0);
      avs_wr(ADDR_CONTROL, 32'h5);
      @(negedge clk);
      check("irq_on", 32'(irq), 32'h1);
      avs_wr(ADDR_DATA, 32'h99);
      check("irq_push_drop", 32'(irq), 32'h0);
      wait_word("irq_word", 32'h8000_0099, t);
      check("irq_slot_end", 32'(irq), 32'h0);
      @(negedge clk);
      check("irq_after_slot", 32'(irq), 32'h1);
      avs_rd(ADDR_CONTROL, rd);
      check("irq_control", rd, 32'h0000_0005);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
